// File: rtl/cache_responder_l3.sv
// L3-side responder: direct-mapped write-back line store serving L2 line reads and write-backs.
// Optional hit/miss statistics counters are enabled by defining L3_STATS_EN.
module cache_responder_l3 #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int LINE_WIDTH     = 128,
    parameter int OFFSET_WIDTH   = 4,
    parameter int L3_INDEX_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDRESS_WIDTH-1:0] cache_L3_memory_address,
    input  logic                     read_from_L3_request,
    input  logic                     write_back_to_L3_request,
    input  logic [LINE_WIDTH-1:0]    write_back_to_L3_data,
    output logic                     L3_ready,
    output logic [LINE_WIDTH-1:0]    write_data_to_L2_from_L3,
    output logic                     write_back_to_L3_verified,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_read_request,
    output logic                     mem_write_request,
    output logic [LINE_WIDTH-1:0]    mem_write_data,
    input  logic [LINE_WIDTH-1:0]    mem_read_data,
`ifdef L3_STATS_EN
    output logic [15:0]              l3_hit_count,
    output logic [15:0]              l3_miss_count,
`endif
    input  logic                     mem_ready
);

    localparam int TAG_WIDTH = ADDRESS_WIDTH - OFFSET_WIDTH - L3_INDEX_WIDTH;
    localparam int NUM_LINES = 2 ** L3_INDEX_WIDTH;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_EVICT   = 3'd2;
    localparam logic [2:0] S_FILL    = 3'd3;
    localparam logic [2:0] S_RESPOND = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic [2:0]                state;
    logic [2:0]                next_state;
    logic [TAG_WIDTH-1:0]      req_tag;
    logic [L3_INDEX_WIDTH-1:0] req_index;
    logic                      req_is_wb;
    logic [LINE_WIDTH-1:0]     req_data;

    logic [LINE_WIDTH-1:0]     line_store [NUM_LINES];
    logic [TAG_WIDTH-1:0]      tag_store  [NUM_LINES];
    logic [NUM_LINES-1:0]      valid_bits;
    logic [NUM_LINES-1:0]      dirty_bits;

    logic                      hit;
    logic                      victim_dirty;
    logic                      line_we;
    logic [LINE_WIDTH-1:0]     line_wdata;
    logic                      line_dirty;
    logic                      evict_done;
    logic                      served_req;
    logic                      offset_unused;

    // Byte offset selects nothing inside the L3; lines are always moved whole.
    assign offset_unused = ^cache_L3_memory_address[OFFSET_WIDTH-1:0];

    assign hit          = valid_bits[req_index] && (tag_store[req_index] == req_tag);
    assign victim_dirty = valid_bits[req_index] && dirty_bits[req_index];
    assign served_req   = req_is_wb ? write_back_to_L3_request : read_from_L3_request;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        line_we    = 1'b0;
        line_wdata = req_data;
        line_dirty = 1'b1;
        evict_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (write_back_to_L3_request || read_from_L3_request) begin
                    next_state = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    line_we    = req_is_wb;
                    next_state = S_RESPOND;
                end else if (victim_dirty) begin
                    next_state = S_EVICT;
                end else if (req_is_wb) begin
                    line_we    = 1'b1;
                    next_state = S_RESPOND;
                end else begin
                    next_state = S_FILL;
                end
            end
            S_EVICT: begin
                if (mem_ready) begin
                    evict_done = 1'b1;
                    line_we    = req_is_wb;
                    next_state = req_is_wb ? S_RESPOND : S_FILL;
                end
            end
            S_FILL: begin
                if (mem_ready) begin
                    line_we    = 1'b1;
                    line_wdata = mem_read_data;
                    line_dirty = 1'b0;
                    next_state = S_RESPOND;
                end
            end
            S_RESPOND: next_state = S_RELEASE;
            S_RELEASE: begin
                // Only the request just served must drop; a concurrently held read is still pending.
                if (!served_req) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            req_tag    <= '0;
            req_index  <= '0;
            req_is_wb  <= 1'b0;
            req_data   <= '0;
            valid_bits <= '0;
            dirty_bits <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE) begin
                req_tag   <= cache_L3_memory_address[ADDRESS_WIDTH-1 -: TAG_WIDTH];
                req_index <= cache_L3_memory_address[OFFSET_WIDTH +: L3_INDEX_WIDTH];
                req_is_wb <= write_back_to_L3_request;
                req_data  <= write_back_to_L3_data;
            end
            if (evict_done) begin
                dirty_bits[req_index] <= 1'b0;
            end
            if (line_we) begin
                valid_bits[req_index] <= 1'b1;
                dirty_bits[req_index] <= line_dirty;
            end
        end
    end

    // NOTE: line and tag storage are not reset; valid_bits alone decides whether contents count.
    always_ff @(posedge clk) begin
        if (line_we) begin
            line_store[req_index] <= line_wdata;
            tag_store[req_index]  <= req_tag;
        end
    end

    // Responses are registered, so the pulse lands one cycle after the RESPOND state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            L3_ready                  <= 1'b0;
            write_back_to_L3_verified <= 1'b0;
            write_data_to_L2_from_L3  <= '0;
        end else begin
            L3_ready                  <= (state == S_RESPOND) && !req_is_wb;
            write_back_to_L3_verified <= (state == S_RESPOND) && req_is_wb;
            write_data_to_L2_from_L3  <= ((state == S_RESPOND) && !req_is_wb) ?
                                         line_store[req_index] : '0;
        end
    end

    always_comb begin
        mem_read_request  = (state == S_FILL);
        mem_write_request = (state == S_EVICT);
        mem_write_data    = '0;
        mem_address       = '0;
        if (state == S_EVICT) begin
            mem_address    = {tag_store[req_index], req_index, {OFFSET_WIDTH{1'b0}}};
            mem_write_data = line_store[req_index];
        end else if (state == S_FILL) begin
            mem_address    = {req_tag, req_index, {OFFSET_WIDTH{1'b0}}};
        end
    end

`ifdef L3_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l3_hit_count  <= '0;
            l3_miss_count <= '0;
        end else if (state == S_LOOKUP) begin
            if (hit && (l3_hit_count != 16'hFFFF)) begin
                l3_hit_count <= l3_hit_count + 16'd1;
            end
            if (!hit && (l3_miss_count != 16'hFFFF)) begin
                l3_miss_count <= l3_miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_responder_l3.sv
// Directed bench for cache_responder_l3 with a fixed-latency main-memory model.
module tb_cache_responder_l3;

    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          rd_req = 1'b0;
    logic          wb_req = 1'b0;
    logic [LW-1:0] wb_data = '0;
    logic          L3_ready;
    logic [LW-1:0] l2_data;
    logic          verified;
    logic [AW-1:0] mem_address;
    logic          mem_read_request;
    logic          mem_write_request;
    logic [LW-1:0] mem_write_data;
    logic [LW-1:0] mem_read_data = '0;
    logic          mem_ready = 1'b0;
`ifdef L3_STATS_EN
    logic [15:0]   l3_hit_count;
    logic [15:0]   l3_miss_count;
`endif

    cache_responder_l3 dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .cache_L3_memory_address   (addr),
        .read_from_L3_request      (rd_req),
        .write_back_to_L3_request  (wb_req),
        .write_back_to_L3_data     (wb_data),
        .L3_ready                  (L3_ready),
        .write_data_to_L2_from_L3  (l2_data),
        .write_back_to_L3_verified (verified),
        .mem_address               (mem_address),
        .mem_read_request          (mem_read_request),
        .mem_write_request         (mem_write_request),
        .mem_write_data            (mem_write_data),
        .mem_read_data             (mem_read_data),
`ifdef L3_STATS_EN
        .l3_hit_count              (l3_hit_count),
        .l3_miss_count             (l3_miss_count),
`endif
        .mem_ready                 (mem_ready)
    );

    always #5 clk = ~clk;

    // Memory model: completes each request after mem_lat waiting cycles and logs it.
    int            mem_lat = 3;
    int            wait_cnt = 0;
    int            rd_cnt = 0;
    int            wr_cnt = 0;
    int            req_cycles = 0;
    int            rd_cnt_at_wr = 0;
    logic [LW-1:0] fill_line = '0;
    logic [AW-1:0] last_rd_addr = '0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [LW-1:0] last_wr_data = '0;

    always @(negedge clk) begin
        if (mem_ready) begin
            mem_ready     = 1'b0;
            mem_read_data = '0;
            wait_cnt      = 0;
        end else if (!reset_n || !(mem_read_request || mem_write_request)) begin
            wait_cnt = 0;
        end else begin
            req_cycles++;
            if (wait_cnt == mem_lat) begin
                mem_ready = 1'b1;
                if (mem_read_request) begin
                    mem_read_data = fill_line;
                    rd_cnt++;
                    last_rd_addr = mem_address;
                end else begin
                    wr_cnt++;
                    last_wr_addr = mem_address;
                    last_wr_data = mem_write_data;
                    rd_cnt_at_wr = rd_cnt;
                end
            end else begin
                wait_cnt++;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges are counted from the one that samples the request (edge N counts as 1).
    task automatic wait_resp(input bit want_wb, output int edges, output logic [LW-1:0] data);
        edges = 0;
        data  = '0;
        for (int i = 0; i < 60; i++) begin
            step();
            edges++;
            if (want_wb ? verified : L3_ready) begin
                data = l2_data;
                return;
            end
        end
        edges = -1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output int edges, output logic [LW-1:0] d);
        addr   = a;
        rd_req = 1'b1;
        wait_resp(1'b0, edges, d);
        rd_req = 1'b0;
        step();
        check("ready_pulse_width", {127'd0, L3_ready}, 128'd0);
    endtask

    int            edges;
    int            pulses;
    int            reqc0;
    bit            seen;
    logic [LW-1:0] d;

    initial begin
        // Reset state
        step();
        step();
        check("rst_ready", {127'd0, L3_ready}, 128'd0);
        check("rst_verified", {127'd0, verified}, 128'd0);
        check("rst_mem_rd", {127'd0, mem_read_request}, 128'd0);
        check("rst_mem_wr", {127'd0, mem_write_request}, 128'd0);
        check("rst_mem_addr", {96'd0, mem_address}, 128'd0);
        check("rst_l2_data", l2_data, 128'd0);
        reset_n = 1'b1;
        step();

        // Cold read miss: single fill, no write
        fill_line = {16{8'hA5}};
        do_read(32'h0000_0040, edges, d);
        check("cold_responded", {127'd0, edges > 0}, 128'd1);
        check("cold_data", d, {16{8'hA5}});
        check("cold_rd_cnt", rd_cnt, 1);
        check("cold_wr_cnt", wr_cnt, 0);
        check("cold_rd_addr", {96'd0, last_rd_addr}, 128'h40);

        // Repeat read hits: pulse after edge N+2, memory untouched
        reqc0 = req_cycles;
        do_read(32'h0000_0040, edges, d);
        check("hit_latency", edges, 3);
        check("hit_data", d, {16{8'hA5}});
        check("hit_mem_idle", req_cycles - reqc0, 0);

        // Write-back hit then read returns written line
        addr    = 32'h0000_0040;
        wb_data = {8{16'h1234}};
        wb_req  = 1'b1;
        wait_resp(1'b1, edges, d);
        wb_req = 1'b0;
        check("wb_latency", edges, 3);
        step();
        check("wb_pulse_width", {127'd0, verified}, 128'd0);
        do_read(32'h0000_0040, edges, d);
        check("rd_after_wb_latency", edges, 3);
        check("rd_after_wb_data", d, {8{16'h1234}});
        check("wb_mem_idle", req_cycles - reqc0, 0);

        // Conflict miss: dirty victim evicted to 0x40, then fill of 0x440
        fill_line = {16{8'hC3}};
        do_read(32'h0000_0440, edges, d);
        check("conf_data", d, {16{8'hC3}});
        check("conf_wr_cnt", wr_cnt, 1);
        check("conf_wr_addr", {96'd0, last_wr_addr}, 128'h40);
        check("conf_wr_data", last_wr_data, {8{16'h1234}});
        check("conf_wr_before_rd", rd_cnt_at_wr, 1);
        check("conf_rd_cnt", rd_cnt, 2);
        check("conf_rd_addr", {96'd0, last_rd_addr}, 128'h440);

        // Request held 5 cycles past the pulse: exactly one response
        addr   = 32'h0000_0440;
        rd_req = 1'b1;
        wait_resp(1'b0, edges, d);
        pulses = (edges > 0) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (L3_ready) pulses++;
        end
        rd_req = 1'b0;
        step();
        step();
        if (L3_ready) pulses++;
        check("held_single_pulse", pulses, 1);

        // Both requests high: write-back first, then the read sees the written line
        reqc0   = req_cycles;
        addr    = 32'h0000_0080;
        wb_data = {4{32'hDEAD_BEEF}};
        wb_req  = 1'b1;
        rd_req  = 1'b1;
        wait_resp(1'b1, edges, d);
        check("both_wb_first", {127'd0, edges > 0 && !L3_ready}, 128'd1);
        wb_req = 1'b0;
        wait_resp(1'b0, edges, d);
        rd_req = 1'b0;
        step();
        check("both_rd_data", d, {4{32'hDEAD_BEEF}});
        check("both_mem_idle", req_cycles - reqc0, 0);
        check("both_wr_cnt", wr_cnt, 1);

`ifdef L3_STATS_EN
        check("stats_hits", {112'd0, l3_hit_count}, 128'd5);
        check("stats_misses", {112'd0, l3_miss_count}, 128'd3);
`endif

        // Reset during FILL drops the fill and invalidates the store
        addr   = 32'h0000_0840;
        rd_req = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = mem_read_request;
        end
        check("fill_started", {127'd0, seen}, 128'd1);
        check("fill_addr", {96'd0, mem_address}, 128'h840);
        reset_n = 1'b0;
        #1;
        check("mid_rst_mem_rd", {127'd0, mem_read_request}, 128'd0);
        check("mid_rst_mem_addr", {96'd0, mem_address}, 128'd0);
        check("mid_rst_ready", {127'd0, L3_ready}, 128'd0);
        rd_req = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        check("mid_rst_rd_cnt", rd_cnt, 2);
`ifdef L3_STATS_EN
        check("stats_rst_hits", {112'd0, l3_hit_count}, 128'd0);
`endif
        fill_line = {16{8'h5A}};
        do_read(32'h0000_0440, edges, d);
        check("post_rst_data", d, {16{8'h5A}});
        check("post_rst_rd_cnt", rd_cnt, 3);
        check("post_rst_rd_addr", {96'd0, last_rd_addr}, 128'h440);
        check("post_rst_wr_cnt", wr_cnt, 1);
`ifdef L3_STATS_EN
        check("stats_post_misses", {112'd0, l3_miss_count}, 128'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
